tft_pattern_gen: RTL and testbench



---
 rtl/tft_pkg.sv | 39 +++
 rtl/tft_pattern_color.sv | 54 +++++
 rtl/tft_pattern_gen.sv | 118 +++++++++++
 tb/tb_tft_pattern_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/tft_pkg.sv
// Shared constants for the TFT test-pattern generator: RGB565 colours,
// pattern mode codes and default raster size.
package tft_pkg;

    localparam int H_RES_DEF = 320;
    localparam int V_RES_DEF = 240;

    typedef enum logic [1:0] {
        MODE_SOLID    = 2'd0,
        MODE_BARS     = 2'd1,
        MODE_CHECKER  = 2'd2,
        MODE_GRADIENT = 2'd3
    } mode_e;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tft_pattern_color.sv
// Combinational RGB565 colour for one pixel from mode, coordinates and frame count.
// TFT_PATTERN_SCROLL_EN: bars and checkerboard scroll horizontally one pixel per frame.
module tft_pattern_color
    import tft_pkg::*;
#(
    parameter int H_RES        = H_RES_DEF,
    parameter int CHECKER_LOG2 = 4,
    parameter int FCNT_W       = 8
) (
    input  logic [1:0]        in_mode,
    input  logic [8:0]        in_x,
    input  logic [8:0]        in_y,
    input  logic [FCNT_W-1:0] in_frame,
    input  logic [15:0]       in_fill,
    output logic [15:0]       out_color
);

    logic [8:0] w_xs;
    logic [2:0] w_bar_idx;
    logic       w_unused;

`ifdef TFT_PATTERN_SCROLL_EN
    // Single conditional subtract is enough while the frame count stays below H_RES.
    logic [9:0] w_xsum;
    assign w_xsum = {1'b0, in_x} + 10'(in_frame);
    assign w_xs   = (w_xsum >= 10'(H_RES)) ? 9'(w_xsum - 10'(H_RES)) : w_xsum[8:0];
`else
    assign w_xs = in_x;
`endif

    // Bar index = xs*8/H_RES, found by counting the constant thresholds already passed.
    always_comb begin
        w_bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (int'(w_xs) >= (k * H_RES) / 8) begin
                w_bar_idx = w_bar_idx + 3'd1;
            end
        end
    end

    always_comb begin
        out_color = RGB_BLACK;
        case (mode_e'(in_mode))
            MODE_SOLID:    out_color = in_fill;
            MODE_BARS:     out_color = bar_color(w_bar_idx);
            MODE_CHECKER:  out_color = (w_xs[CHECKER_LOG2] ^ in_y[CHECKER_LOG2]) ? RGB_WHITE : RGB_BLACK;
            MODE_GRADIENT: out_color = {in_x[8:4], in_y[7:2], in_frame[4:0]};
            default:       out_color = RGB_BLACK;
        endcase
    end

    assign w_unused = ^{in_y, in_frame};

endmodule

// File: rtl/tft_pattern_gen.sv
// ILI9341 pixel source: raster-ordered RGB565 stream with valid/ready handshake.
// Define TFT_PATTERN_SCROLL_EN to make bars/checkerboard scroll one pixel per frame.
module tft_pattern_gen
    import tft_pkg::*;
#(
    parameter int H_RES        = H_RES_DEF,
    parameter int V_RES        = V_RES_DEF,
    parameter int CHECKER_LOG2 = 4,
    parameter int FCNT_W       = 8
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_enable,
    input  logic [1:0]        in_mode,
    input  logic [15:0]       in_fill_color,
    input  logic              in_pix_ready,
    output logic              out_pix_valid,
    output logic [15:0]       out_pix_data,
    output logic [8:0]        out_pix_x,
    output logic [8:0]        out_pix_y,
    output logic              out_sof,
    output logic              out_eof,
    output logic [FCNT_W-1:0] out_frame_cnt
);

    logic [8:0]        r_x;
    logic [8:0]        r_y;
    logic [1:0]        r_mode;
    logic [15:0]       r_fill;
    logic              r_valid;
    logic [15:0]       r_data;
    logic [8:0]        r_pix_x;
    logic [8:0]        r_pix_y;
    logic              r_sof;
    logic              r_eof;
    logic [FCNT_W-1:0] r_frame_cnt;

    logic              w_take;
    logic              w_load;
    logic              w_first;
    logic              w_last_x;
    logic              w_last_y;
    logic [1:0]        w_mode;
    logic [15:0]       w_fill;
    logic [15:0]       w_color;

    assign w_take   = !r_valid || in_pix_ready;
    assign w_load   = w_take && in_enable;
    assign w_first  = (r_x == 9'd0) && (r_y == 9'd0);
    assign w_last_x = (r_x == 9'(H_RES - 1));
    assign w_last_y = (r_y == 9'(V_RES - 1));

    // Pixel (0,0) is coloured from the live inputs, the rest of the frame from the latched copy.
    assign w_mode = w_first ? in_mode       : r_mode;
    assign w_fill = w_first ? in_fill_color : r_fill;

    tft_pattern_color #(
        .H_RES        (H_RES),
        .CHECKER_LOG2 (CHECKER_LOG2),
        .FCNT_W       (FCNT_W)
    ) u_color (
        .in_mode   (w_mode),
        .in_x      (r_x),
        .in_y      (r_y),
        .in_frame  (r_frame_cnt),
        .in_fill   (w_fill),
        .out_color (w_color)
    );

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            r_x         <= '0;
            r_y         <= '0;
            r_mode      <= '0;
            r_fill      <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
            r_frame_cnt <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= w_color;
            r_pix_x <= r_x;
            r_pix_y <= r_y;
            r_sof   <= w_first;
            r_eof   <= w_last_x && w_last_y;
            if (w_first) begin
                r_mode <= in_mode;
                r_fill <= in_fill_color;
            end
            if (w_last_x) begin
                r_x <= '0;
                if (w_last_y) begin
                    r_y         <= '0;
                    r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
                end else begin
                    r_y <= r_y + 9'd1;
                end
            end else begin
                r_x <= r_x + 9'd1;
            end
        end else if (w_take) begin
            r_valid <= 1'b0;
        end
    end

    assign out_pix_valid = r_valid;
    assign out_pix_data  = r_data;
    assign out_pix_x     = r_pix_x;
    assign out_pix_y     = r_pix_y;
    assign out_sof       = r_sof;
    assign out_eof       = r_eof;
    assign out_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_tft_pattern_gen.sv
// Directed self-checking bench for tft_pattern_gen at the full 320x240 raster.
module tb_tft_pattern_gen;

    logic        in_clk = 1'b0;
    logic        in_rst_n;
    logic        in_enable;
    logic [1:0]  in_mode;
    logic [15:0] in_fill_color;
    logic        in_pix_ready;
    logic        out_pix_valid;
    logic [15:0] out_pix_data;
    logic [8:0]  out_pix_x;
    logic [8:0]  out_pix_y;
    logic        out_sof;
    logic        out_eof;
    logic [7:0]  out_frame_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int bad;
    int gaps;
    int ex;
    int ey;
    int          bar_x[8] = '{0, 39, 40, 100, 160, 279, 280, 319};
    logic [15:0] bar_c[8] = '{16'hFFFF, 16'hFFFF, 16'hFFE0, 16'h07FF,
                              16'hF81F, 16'h001F, 16'h0000, 16'h0000};

    always #5 in_clk = ~in_clk;

    tft_pattern_gen #(
        .H_RES        (320),
        .V_RES        (240),
        .CHECKER_LOG2 (4),
        .FCNT_W       (8)
    ) dut (
        .in_clk        (in_clk),
        .in_rst_n      (in_rst_n),
        .in_enable     (in_enable),
        .in_mode       (in_mode),
        .in_fill_color (in_fill_color),
        .in_pix_ready  (in_pix_ready),
        .out_pix_valid (out_pix_valid),
        .out_pix_data  (out_pix_data),
        .out_pix_x     (out_pix_x),
        .out_pix_y     (out_pix_y),
        .out_sof       (out_sof),
        .out_eof       (out_eof),
        .out_frame_cnt (out_frame_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance with ready=1 until the DUT presents pixel (wx,wy); sampled on negedges.
    task automatic wait_pix(input int wx, input int wy);
        bit found = 1'b0;
        for (int k = 0; k < 100000; k++) begin
            if (out_pix_valid && out_pix_x == wx[8:0] && out_pix_y == wy[8:0]) begin
                found = 1'b1;
                break;
            end
            @(negedge in_clk);
        end
        if (!found) check("wait_pix", {out_pix_x, out_pix_y}, {wx[8:0], wy[8:0]});
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_rst_n      = 1'b0;
        in_enable     = 1'b1;
        in_pix_ready  = 1'b1;
        in_mode       = 2'd0;
        in_fill_color = 16'hF800;
        repeat (3) @(negedge in_clk);
        check("rst_valid", out_pix_valid, 1'b0);
        check("rst_data", out_pix_data, 16'h0000);
        check("rst_xy", {out_pix_x, out_pix_y}, 18'd0);
        check("rst_sof_eof_fcnt", {out_sof, out_eof, out_frame_cnt}, 10'd0);
        in_rst_n = 1'b1;
        @(negedge in_clk);

        // Frame 0: solid red; mode/fill changes mid-frame must not take effect.
        check("f0_first", {out_pix_valid, out_sof, out_pix_x, out_pix_y, out_pix_data},
              {1'b1, 1'b1, 9'd0, 9'd0, 16'hF800});
        bad = 0;
        ex  = 0;
        ey  = 0;
        for (int n = 0; n < 76800; n++) begin
            if (!out_pix_valid || out_pix_x != 9'(ex) || out_pix_y != 9'(ey) ||
                out_pix_data != 16'hF800 || out_sof != (n == 0) || out_eof != (n == 76799))
                bad++;
            if (ex == 5 && ey == 10) begin
                in_mode       = 2'd3;
                in_fill_color = 16'h1234;
            end
            if (n != 76799) begin
                if (ex == 319) begin
                    ex = 0;
                    ey++;
                end else begin
                    ex++;
                end
                @(negedge in_clk);
            end
        end
        check("f0_stream_bad", bad, 0);
        check("f0_eof", {out_eof, out_pix_x, out_pix_y}, {1'b1, 9'd319, 9'd239});
        check("f0_fcnt", out_frame_cnt, 8'd1);

        // Frame 1: gradient with f=1.
        @(negedge in_clk);
        check("f1_sof", {out_sof, out_eof, out_pix_x, out_pix_y}, {1'b1, 1'b0, 9'd0, 9'd0});
        check("f1_grad_0_0", out_pix_data, 16'h0001);
        check("f1_fcnt", out_frame_cnt, 8'd1);
        wait_pix(100, 0);
        check("f1_grad_100_0", out_pix_data, 16'h3001);

        // Backpressure: ready 1-0-0-1 at x=100.
        wait_pix(100, 1);
        check("bp_data", out_pix_data, 16'h3001);
        in_pix_ready = 1'b0;
        @(negedge in_clk);
        check("bp_hold1", {out_pix_valid, out_pix_x, out_pix_y, out_pix_data},
              {1'b1, 9'd100, 9'd1, 16'h3001});
        in_enable     = 1'b0;
        in_fill_color = 16'hABCD;
        @(negedge in_clk);
        check("bp_hold2", {out_pix_valid, out_pix_x, out_pix_y, out_pix_data},
              {1'b1, 9'd100, 9'd1, 16'h3001});
        in_pix_ready = 1'b1;
        in_enable    = 1'b1;
        @(negedge in_clk);
        check("bp_next", {out_pix_valid, out_pix_x, out_pix_y}, {1'b1, 9'd101, 9'd1});

        // Enable gap of 10 cycles after pixel (150,1).
        wait_pix(150, 1);
        in_enable = 1'b0;
        gaps = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge in_clk);
            if (out_pix_valid) gaps++;
        end
        check("en_gap_valid", gaps, 0);
        in_enable = 1'b1;
        @(negedge in_clk);
        check("en_resume", {out_pix_valid, out_pix_x, out_pix_y, out_pix_data},
              {1'b1, 9'd151, 9'd1, 16'h4801});

        wait_pix(319, 2);
        check("f1_grad_319_2", out_pix_data, 16'h9801);
        wait_pix(17, 4);
        check("f1_grad_17_4", {out_sof, out_eof, out_pix_data}, {1'b0, 1'b0, 16'h0821});

        // Mid-frame reset; next frame is checkerboard.
        wait_pix(200, 4);
        in_rst_n = 1'b0;
        in_mode  = 2'd2;
        @(negedge in_clk);
        check("mrst_valid", {out_pix_valid, out_frame_cnt}, {1'b0, 8'd0});
        in_rst_n = 1'b1;
        @(negedge in_clk);
        check("mrst_restart", {out_pix_valid, out_sof, out_eof, out_pix_x, out_pix_y, out_frame_cnt},
              {1'b1, 1'b1, 1'b0, 9'd0, 9'd0, 8'd0});
        check("chk_0_0", out_pix_data, 16'h0000);
        wait_pix(16, 0);
        check("chk_16_0", out_pix_data, 16'hFFFF);
        wait_pix(5, 10);
        in_mode = 2'd3;
        check("chk_5_10", out_pix_data, 16'h0000);
        wait_pix(0, 16);
        check("chk_0_16", out_pix_data, 16'hFFFF);
        wait_pix(16, 16);
        check("chk_16_16", out_pix_data, 16'h0000);

        // Reset again with colour bars selected.
        wait_pix(20, 16);
        in_rst_n = 1'b0;
        in_mode  = 2'd1;
        @(negedge in_clk);
        in_rst_n = 1'b1;
        @(negedge in_clk);
        check("bars_sof", {out_sof, out_pix_x, out_pix_y}, {1'b1, 9'd0, 9'd0});
        for (int y = 0; y < 2; y++) begin
            for (int i = 0; i < 8; i++) begin
                wait_pix(bar_x[i], y);
                check($sformatf("bar_x%0d_y%0d", bar_x[i], y), out_pix_data, bar_c[i]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
